imem_responder: RTL and testbench
=================================

# imem_responder

Synthesizable memory-side responder for the processor/memory bus: accepts `BUS_LOAD`/`BUS_STORE` commands from a requester (e.g. the instruction cache), grants a nonzero transaction tag in the same cycle, and returns 64-bit load data with that tag after a fixed latency. It sits at the memory end of the bus, replacing the behavioural memory model in synthesized/emulated builds, and lets cache blocks be verified against a cycle-exact target.

## Interface
- `MEM_LATENCY`, 4, cycles from command acceptance to data return (≥1)
- `NUM_TAGS`, 15, tags available, values 1..NUM_TAGS (≤15); 0 means "no tag / rejected"
- `MEM_WORDS`, 8192, depth in 64-bit words (power of two)
- `clock`  in  1  single clock; all state on posedge
- `reset`  in  1  asynchronous, active-low reset
- `proc2mem_command`  in  2  `BUS_NONE`=0, `BUS_LOAD`=1, `BUS_STORE`=2
- `proc2mem_addr`  in  `XLEN`  byte address; bits [2:0] ignored
- `proc2mem_data`  in  64  store data
- `mem2proc_response`  out  4  combinational grant tag for current command; 0 = rejected/none
- `mem2proc_data`  out  64  registered load return data
- `mem2proc_tag`  out  4  registered tag of returning load; 0 = nothing returning

## Operation
- Word index = `proc2mem_addr[3 +: $clog2(MEM_WORDS)]`; upper address bits ignored (aliasing).
- Free-tag bitmap, NUM_TAGS bits, all set after reset. Grant = lowest-numbered free tag.
- LOAD: if a tag is free, `mem2proc_response` = granted tag; at the edge, tag marked busy, memory word read, {valid, tag, data} enters stage 0 of a MEM_LATENCY-deep shift pipeline. If no tag is free, response = 0, nothing enqueued; requester must re-present.
- STORE: see Configuration. Stores never occupy pipeline or tag.
- `BUS_NONE` or reserved code 3: response = 0, no state change.
- Pipeline shifts every cycle unconditionally; final stage registers into `mem2proc_tag`/`mem2proc_data`. Empty stage → tag 0, data 0.
- Returned tag freed at the edge ending its return cycle; may be regranted from the next cycle.
- Loads return strictly in acceptance order; at most one return per cycle.
- Load data is memory content at acceptance edge (store in same cycle to same word: load sees old data).

## Timing
- Command valid in cycle N → `mem2proc_response` valid in cycle N (combinational from inputs and registered bitmap).
- Load accepted in N → `mem2proc_tag`/`mem2proc_data` valid for exactly one cycle, N+MEM_LATENCY.
- Back-to-back loads: one per cycle, sustained, while tags are free; with NUM_TAGS ≥ MEM_LATENCY+1, never rejects.
- Reset asserted (low) at any time: pipeline cleared, bitmap all free, `mem2proc_tag`=0, `mem2proc_data`=0; in-flight loads discarded, never returned. Memory array contents not reset.
- Reset values: `mem2proc_tag` 0, `mem2proc_data` 0; `mem2proc_response` 0 while reset low.

## Configuration
- `IMEM_RESP_STORE_EN` defined: STORE with any free tag → response = lowest free tag (not marked busy), word written with `proc2mem_data` at the edge; visible to loads accepted from N+1.
- Undefined: STORE response = 0, memory untouched; block is read-only (instruction memory, preloaded via `$readmemh` in simulation).

## Structure
- Shared package: `BUS_COMMAND` encoding (already in system defs), `MEM_PIPE_ENTRY` struct {valid, tag[3:0], data[63:0]}, default `MEM_LATENCY`/`NUM_TAGS` constants.
- Sub-module `mem_tag_alloc`: free bitmap, lowest-free priority encoder, grant/free ports, simultaneous grant+free of different tags in one edge.
- Top holds memory array, pipeline, output registers.

## Test plan
- Reset then LOAD addr 0x100 (word 0x20 = 64'hDEADBEEF_01234567) in cycle 0 → response 1 in cycle 0; tag 1 with that data in cycle 4 only.
- Loads to 0x0, 0x8, 0x10, 0x18 in cycles 0–3 → responses 1,2,3,4; tags 1–4 return in cycles 4–7 in order; tag 1 regranted to load in cycle 5.
- NUM_TAGS=2, MEM_LATENCY=4: loads every cycle → cycles 0,1 granted 1,2; cycles 2–4 response 0; cycle 5 grants 1 again.
- With `IMEM_RESP_STORE_EN`: STORE 0x40 data 64'hA5A5 in cycle 0 plus LOAD 0x40 cycle 0 → load returns old word; LOAD 0x40 cycle 1 returns 64'hA5A5. Without macro: STORE response 0, load returns old word.
- Two loads in flight, reset low in cycle 2 → `mem2proc_tag` stays 0 through cycle 10; first load after reset release gets tag 1.
- Command code 3 and `BUS_NONE` → response 0, no return, bitmap unchanged.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared bus encodings, pipeline entry layout and default sizing for the memory-side responder.
package imem_responder_pkg;

  localparam int XLEN            = 32;
  localparam int TAG_W           = 4;
  localparam int MAX_TAGS        = 15;
  localparam int DEF_MEM_LATENCY = 4;
  localparam int DEF_NUM_TAGS    = 15;
  localparam int DEF_MEM_WORDS   = 8192;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } BUS_COMMAND;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } MEM_PIPE_ENTRY;

  // Tag numbering is 1-based so that 0 can mean "no tag"; bit i of the vector is tag i+1.
  function automatic logic [TAG_W-1:0] lowest_free(input logic [MAX_TAGS-1:0] free_vec);
    logic [TAG_W-1:0] tag;
    tag = '0;
    for (int i = MAX_TAGS - 1; i >= 0; i--) begin
      if (free_vec[i]) tag = TAG_W'(i + 1);
    end
    return tag;
  endfunction

endpackage

// File: rtl/imem_responder_tag_alloc.sv
// mem_tag_alloc: free-tag bitmap with combinational lowest-free grant; busy at the accepting edge.
// A grant and the release of a different (returning) tag can both land on the same edge.
module mem_tag_alloc
  import imem_responder_pkg::*;
#(
  parameter int NUM_TAGS = DEF_NUM_TAGS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             take,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] grant_tag
);

  logic [NUM_TAGS-1:0] free_q;
  logic [NUM_TAGS-1:0] free_d;
  logic [MAX_TAGS-1:0] free_pad;

  always_comb begin
    free_pad                 = '0;
    free_pad[NUM_TAGS-1:0]   = free_q;
    grant_tag                = (req && reset) ? lowest_free(free_pad) : '0;

    free_d = free_q;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (free_en && (free_tag == TAG_W'(t))) free_d[t-1] = 1'b1;
      if (take && (grant_tag == TAG_W'(t)))   free_d[t-1] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q <= '1;
    end else begin
      free_q <= free_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side bus responder: same-cycle tag grant, load data + tag returned exactly MEM_LATENCY cycles later.
// No free tag means response 0 and the requester retries; define IMEM_RESP_STORE_EN to accept stores.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int NUM_TAGS    = DEF_NUM_TAGS,
  parameter int MEM_WORDS   = DEF_MEM_WORDS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2mem_command,
  input  logic [XLEN-1:0]  proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2proc_response,
  output logic [63:0]      mem2proc_data,
  output logic [TAG_W-1:0] mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [63:0]      mem_q [MEM_WORDS];
  MEM_PIPE_ENTRY    pipe_q [MEM_LATENCY];
  MEM_PIPE_ENTRY    pipe_d [MEM_LATENCY];

  BUS_COMMAND       cmd;
  logic [IDX_W-1:0] word_idx;
  logic             is_load;
  logic             is_store;
  logic             load_acc;
  logic             mem_we;
  logic [TAG_W-1:0] grant_tag;
  logic             unused_addr;

  assign cmd         = BUS_COMMAND'(proc2mem_command);
  assign word_idx    = proc2mem_addr[3 +: IDX_W];
  assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IDX_W]};
  assign is_load     = (cmd == BUS_LOAD);

`ifdef IMEM_RESP_STORE_EN
  assign is_store = (cmd == BUS_STORE);
`else
  assign is_store = 1'b0;
`endif

  // Stores only need a free tag to be accepted; they never hold one.
  mem_tag_alloc #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_alloc (
    .clock     (clock),
    .reset     (reset),
    .req       (is_load || is_store),
    .take      (is_load),
    .free_en   (pipe_q[MEM_LATENCY-1].valid),
    .free_tag  (pipe_q[MEM_LATENCY-1].tag),
    .grant_tag (grant_tag)
  );

  assign mem2proc_response = grant_tag;
  assign load_acc          = is_load && (grant_tag != '0);
  assign mem_we            = is_store && (grant_tag != '0);

  always_comb begin
    pipe_d[0] = '0;
    if (load_acc) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].tag   = grant_tag;
      pipe_d[0].data  = mem_q[word_idx];
    end
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // The last stage doubles as the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Memory contents survive reset; a load in the same cycle still reads the pre-edge word.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[word_idx] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = pipe_q[MEM_LATENCY-1].tag;
  assign mem2proc_data = pipe_q[MEM_LATENCY-1].data;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder with a cycle-level reference model.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int LAT = 4;
  localparam int NT  = 2;
  localparam int PRE = 64;

`ifdef IMEM_RESP_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd   = 2'd0;
  logic [31:0] addr  = '0;
  logic [63:0] wdat  = '0;
  logic [3:0]  resp;
  logic [3:0]  rtag;
  logic [63:0] rdat;

  imem_responder #(
    .MEM_LATENCY (LAT),
    .NUM_TAGS    (NT),
    .MEM_WORDS   (8192)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdat),
    .mem2proc_response (resp),
    .mem2proc_data     (rdat),
    .mem2proc_tag      (rtag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [PRE];
  int          busy_until [1:NT];
  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int t = 1; t <= NT; t++) busy_until[t] = -1000;
  endtask

  // Called just after a rising edge; presents one command for the current cycle.
  task automatic issue(input logic [1:0] c, input int idx, input logic [63:0] d,
                       output logic [3:0] grant);
    logic [15:0] hi;
    logic [2:0]  lo;
    exp_t        e;
    hi   = 16'($urandom);
    lo   = 3'($urandom);
    cmd  = c;
    addr = {hi, 7'd0, 6'(idx), lo};
    wdat = d;
    grant = '0;
    if (reset && (c == 2'd1 || (STORE_EN && c == 2'd2))) begin
      for (int t = NT; t >= 1; t--) begin
        if (busy_until[t] < cyc) grant = 4'(t);
      end
    end
    #1;
    check("response", resp, grant);
    if (grant != 0 && c == 2'd1) begin
      busy_until[grant] = cyc + LAT;
      e.due  = cyc + LAT;
      e.tag  = grant;
      e.data = model_mem[idx];
      exp_q.push_back(e);
    end
    if (grant != 0 && c == 2'd2) model_mem[idx] = d;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_return: tag %0d due cycle %0d, got nothing (cycle %0d)",
                 exp_q[0].tag, exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (rtag !== 4'd0 || rdat !== 64'd0) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_return: tag %0d data %h, required none (cycle %0d)",
                   rtag, rdat, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("return_tag", 64'(rtag), 64'(e.tag));
          check("return_data", rdat, e.data);
        end
      end
    end
  end

  logic [3:0] g;
  logic [3:0] burst_exp [6];

  task automatic random_phase(input int n);
    int r;
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 50) ? 2'd1 : (r < 70) ? 2'd2 : (r < 85) ? 2'd0 : 2'd3;
      issue(c, $urandom_range(0, PRE - 1), {$urandom, $urandom}, g);
    end
  endtask

  initial begin
    for (int i = 0; i < PRE; i++) begin
      model_mem[i]  = {$urandom, $urandom};
      dut.mem_q[i]  = model_mem[i];
    end
    model_mem[32] = 64'hDEADBEEF_01234567;
    dut.mem_q[32] = model_mem[32];
    burst_exp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1};
    clear_model();

    #2 reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_tag", 64'(rtag), 64'd0);
    check("reset_data", rdat, 64'd0);
    issue(2'd1, 5, 64'd0, g);
    check("reset_response", 64'(g), 64'd0);
    reset = 1'b1;

    issue(2'd1, 32, 64'd0, g);
    check("first_grant", 64'(g), 64'd1);
    for (int i = 0; i < LAT + 1; i++) issue(2'd0, 0, 64'd0, g);

    for (int i = 0; i < 6; i++) begin
      issue(2'd1, i, 64'd0, g);
      check("burst_grant", 64'(g), 64'(burst_exp[i]));
    end
    for (int i = 0; i < LAT + 1; i++) issue(2'd0, 0, 64'd0, g);

    issue(2'd2, 8, 64'hA5A5, g);
    check("store_response", 64'(g), STORE_EN ? 64'd1 : 64'd0);
    issue(2'd1, 8, 64'd0, g);
    issue(2'd3, 9, 64'd0, g);
    check("rsvd_response", 64'(g), 64'd0);
    issue(2'd0, 9, 64'd0, g);
    check("none_response", 64'(g), 64'd0);

    random_phase(300);

    for (int i = 0; i < LAT + 1; i++) issue(2'd0, 0, 64'd0, g);
    issue(2'd1, 1, 64'd0, g);
    issue(2'd1, 2, 64'd0, g);
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 8; i++) issue(2'd1, i, 64'd0, g);
    reset = 1'b1;
    issue(2'd1, 3, 64'd0, g);
    check("post_reset_grant", 64'(g), 64'd1);

    random_phase(300);

    for (int i = 0; i < 2 * LAT + 2; i++) issue(2'd0, 0, 64'd0, g);
    done = 1'b1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
